// File: rtl/pico_host_pkg.sv
// Shared types and defaults for the picoMIPS4test host driver.
// Holds the FSM state enum, operand type and default phase lengths.
package pico_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_X,
    SEND_Y,
    WAIT_RES,
    DONE
  } state_t;

  typedef logic [7:0] operand_t;

  localparam int HOLD_X_DEF      = 50;
  localparam int HOLD_Y_DEF      = 10;
  localparam int RESULT_WAIT_DEF = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
// Ports: clk, rst_n, load, load_val[W-1:0] in; zero out.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pico_host_driver.sv
// Host sequencer: drives SW/branch_status to picoMIPS4test, captures LED.
// In: fastclk, reset(n), start, x_in, y_in, LED. Out: busy, done, result, SW, branch_status.
module pico_host_driver
  import pico_host_pkg::*;
#(
  parameter int HOLD_X      = HOLD_X_DEF,
  parameter int HOLD_Y      = HOLD_Y_DEF,
  parameter int RESULT_WAIT = RESULT_WAIT_DEF
) (
  input  logic       fastclk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] SW,
  output logic       branch_status,
  input  logic [7:0] LED
);

  localparam int CW = $clog2(max3(HOLD_X, HOLD_Y, RESULT_WAIT)) + 1;

  state_t         state_q;
  state_t         state_d;
  operand_t       x_q;
  operand_t       y_q;
  logic           accept;
  logic           ld;
  logic [CW-1:0]  ld_val;
  logic           zero;

  phase_counter #(
    .W(CW)
  ) u_cnt (
    .clk     (fastclk),
    .rst_n   (reset),
    .load    (ld),
    .load_val(ld_val),
    .zero    (zero)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          ld      = 1'b1;
          ld_val  = CW'(HOLD_X - 1);
          state_d = SEND_X;
        end
      end
      SEND_X: begin
        if (zero) begin
          ld      = 1'b1;
          ld_val  = CW'(HOLD_Y - 1);
          state_d = SEND_Y;
        end
      end
      SEND_Y: begin
        if (zero) begin
          ld      = 1'b1;
          ld_val  = CW'(RESULT_WAIT - 1);
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (zero) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q <= x_in;
        y_q <= y_in;
      end
    end
  end

  // Pins are a registered image of the state, one cycle behind it,
  // so LED is captured on the edge that closes the visible wait phase.
  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      SW            <= '0;
      branch_status <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
    end else begin
      SW            <= '0;
      branch_status <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      unique case (1'b1)
        (state_q == SEND_X): begin
          SW            <= x_q;
          branch_status <= 1'b1;
          busy          <= 1'b1;
        end
        (state_q == SEND_Y): begin
          SW   <= y_q;
          busy <= 1'b1;
        end
        (state_q == WAIT_RES): begin
          branch_status <= 1'b1;
          busy          <= 1'b1;
        end
        (state_q == DONE): begin
          done   <= 1'b1;
          result <= LED;
        end
        default: ;
      endcase
    end
  end

endmodule
